// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM request controller.
package sram_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sram_state_e;

    // Even parity: the stored bit makes the byte plus parity bit have an even number of ones.
    function automatic logic parity8(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry in-order response FIFO; push and pop on the same edge keep the count unchanged.
module sram_rsp_fifo #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = slot[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) slot[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// Single-port SRAM with valid/ready request/response channels, byte enables,
// registered reads, 2-entry response buffering and a post-reset clear sequence.
// Optional per-byte parity storage: define SRAM_REQ_CTRL_PARITY_EN.
module sram_req_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W/8-1:0]     req_be,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_perr,
    output logic                    init_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned BE_W  = DATA_W / BYTE_W;
`ifdef SRAM_REQ_CTRL_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + BE_W;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  mem [DEPTH];
    sram_state_e       state;
    logic [ADDR_W-1:0] init_cnt;

    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic [MEM_W-1:0]  cur_word;
    logic [MEM_W-1:0]  wr_word;
    logic              rd_perr_c;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr;

    logic [DATA_W:0]   fifo_dout;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // Room is reserved for the read stage so an accepted read always has a FIFO slot.
    assign req_ready = (state == ST_RUN) && !fifo_full
                       && ((fifo_count + 2'(rd_valid)) < 2'd2);
    assign accept    = req_valid && req_ready;
    assign wr_acc    = accept && req_we;
    assign rd_acc    = accept && !req_we;
    assign cur_word  = mem[req_addr];

    always_comb begin
        wr_word = cur_word;
        for (int i = 0; i < BE_W; i++) begin
            if (req_be[i]) begin
                wr_word[i*BYTE_W +: BYTE_W] = req_wdata[i*BYTE_W +: BYTE_W];
`ifdef SRAM_REQ_CTRL_PARITY_EN
                wr_word[DATA_W+i] = parity8(req_wdata[i*BYTE_W +: BYTE_W]);
`endif
            end
        end
    end

`ifdef SRAM_REQ_CTRL_PARITY_EN
    always_comb begin
        rd_perr_c = 1'b0;
        for (int i = 0; i < BE_W; i++) begin
            rd_perr_c = rd_perr_c
                        | (parity8(cur_word[i*BYTE_W +: BYTE_W]) ^ cur_word[DATA_W+i]);
        end
    end
`else
    assign rd_perr_c = 1'b0;
`endif

    // Clear sequencer: one word per cycle, then RUN until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + ADDR_W'(1);
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_INIT;
            endcase
        end
    end

    // Storage has no reset; INIT zeroes it (zero data has zero parity).
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_acc) begin
            mem[req_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_perr  <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= cur_word[DATA_W-1:0];
                rd_perr <= rd_perr_c;
            end
        end
    end

    sram_rsp_fifo #(
        .W (DATA_W + 1)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_valid),
        .din   ({rd_perr, rd_data}),
        .pop   (rsp_ready),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = fifo_dout[DATA_W-1:0];
    assign rsp_perr  = fifo_dout[DATA_W];

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Scoreboard bench for sram_req_ctrl (ADDR_W=4, DATA_W=16): directed requests push
// expected responses, a monitor pops and compares whenever a response is consumed.
module tb_sram_req_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_perr;
    logic              init_done;

    int tests = 0;
    int fails = 0;
    logic [DATA_W:0] exp_q [$];
    logic            hold_v;
    logic [DATA_W:0] hold_d;

    sram_req_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_perr  (rsp_perr),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every consumed response and hold-stability while stalled.
    always @(negedge clk) begin
        if (rsp_valid && hold_v) check("rsp_stable", 32'({rsp_perr, rsp_rdata}), 32'(hold_d));
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got %0h expected no response", {rsp_perr, rsp_rdata});
            end else begin
                check("rsp_data", 32'({rsp_perr, rsp_rdata}), 32'(exp_q.pop_front()));
            end
        end
        hold_v <= rsp_valid && !rsp_ready;
        hold_d <= {rsp_perr, rsp_rdata};
    end

    // Issue one request starting #1 after a posedge; returns #1 after its accept edge.
    task automatic send(input logic we, input logic [ADDR_W-1:0] addr, input logic [BE_W-1:0] be,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W:0] exp);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got req_ready=0 expected accept within 200 cycles");
        end else begin
            if (!we) exp_q.push_back(exp);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_init(output int n, output int bad);
        n   = 0;
        bad = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready !== init_done) bad++;
            if (init_done) break;
        end
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        int bad;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        idle(3);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_perr",  32'(rsp_perr),  32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        // 1: clear sequence length and cleared contents
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(n, bad);
        check("init_cycles", 32'(n), 32'd16);
        check("ready_tracks_init", 32'(bad), 32'd0);
        check("ready_after_init", 32'(req_ready), 32'd1);
        send(1'b0, 4'h0, 2'b00, 16'h0000, 17'h00000);
        send(1'b0, 4'hF, 2'b00, 16'h0000, 17'h00000);
        idle(3);

        // 2: write then read next cycle, response one cycle after accept
        send(1'b1, 4'h0, 2'b11, 16'hA5C3, 17'h00000);
        send(1'b0, 4'h0, 2'b00, 16'h0000, 17'h0A5C3);
        check("rsp_valid_at_accept", 32'(rsp_valid), 32'd0);
        idle(1);
        check("rsp_valid_next", 32'(rsp_valid), 32'd1);
        check("rsp_rdata_next", 32'(rsp_rdata), 32'hA5C3);

        // 3: byte-masked write, and be=0 no-op
        send(1'b1, 4'hF, 2'b11, 16'hFFFF, 17'h00000);
        send(1'b1, 4'hF, 2'b01, 16'h1234, 17'h00000);
        send(1'b0, 4'hF, 2'b00, 16'h0000, 17'h0FF34);
        send(1'b1, 4'h0, 2'b00, 16'h1111, 17'h00000);
        send(1'b0, 4'h0, 2'b00, 16'h0000, 17'h0A5C3);
        idle(3);

        // 4: back-pressure with two outstanding, then in-order drain
        rsp_ready = 1'b0;
        send(1'b0, 4'h0, 2'b00, 16'h0000, 17'h0A5C3);
        send(1'b0, 4'hF, 2'b00, 16'h0000, 17'h0FF34);
        for (int i = 0; i < 4; i++) begin
            check("ready_when_full", 32'(req_ready), 32'd0);
            idle(1);
        end
        check("fifo_full_valid", 32'(rsp_valid), 32'd1);
        fork
            send(1'b0, 4'h5, 2'b00, 16'h0000, 17'h00000);
            begin
                idle(2);
                rsp_ready = 1'b1;
            end
        join
        idle(4);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset with reads outstanding drops them and re-clears memory
        send(1'b1, 4'h0, 2'b11, 16'h5A5A, 17'h00000);
        rsp_ready = 1'b0;
        send(1'b0, 4'h0, 2'b00, 16'h0000, 17'h05A5A);
        send(1'b0, 4'hF, 2'b00, 16'h0000, 17'h0FF34);
        idle(1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd0);
        check("rst_mid_init_done", 32'(init_done), 32'd0);
        exp_q.delete();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        wait_init(n, bad);
        check("reinit_cycles", 32'(n), 32'd16);
        send(1'b0, 4'h0, 2'b00, 16'h0000, 17'h00000);
        send(1'b0, 4'hF, 2'b00, 16'h0000, 17'h00000);
        idle(3);

        // 6: parity error reporting
`ifdef SRAM_REQ_CTRL_PARITY_EN
        dut.mem[3][0] = ~dut.mem[3][0];
        send(1'b0, 4'h3, 2'b00, 16'h0000, 17'h10001);
`else
        send(1'b1, 4'h3, 2'b11, 16'h00F0, 17'h00000);
        send(1'b0, 4'h3, 2'b00, 16'h0000, 17'h000F0);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
